// File: rtl/lcd_ctrl.sv
// lcd_ctrl: drives a KS0108-style 128x64 graphic LCD from a byte source.
//
// After reset it holds LCD_rst low, sends display-on (0x3F) and start-line
// (0xC0) to both halves, then refreshes one half page by page. For every
// column it asks upstream for a byte with a one-cycle `en` pulse and waits,
// with no timeout, for `data_valid` before writing that byte to the LCD.
//
// Every LCD bus write has three phases, each EN_CYCLES clocks long:
// SETUP, HIGH (LCD_en=1) and HOLD. LCD_data, LCD_di and LCD_cs are held
// constant for the whole write. Between writes LCD_cs=00 and LCD_en=0.
//
// Optional feature: define LCD_CLEAR_ON_INIT_EN to zero both halves
// (LCD_cs=11, 8 pages x 64 bytes of 0x00) before the refresh loop starts.
//
// Ports:
//   clk         in   global clock
//   rst         in   synchronous active-high reset
//   data_valid  in   data_in carries the requested column byte this cycle
//   data_in     in   column byte, bit0 = top pixel row of the page
//   en          out  one-cycle request for the next column byte
//   frame_done  out  one-cycle pulse after the page-7 / column-63 write
//   LCD_rst     out  LCD reset, active low
//   LCD_cs      out  LCD half select, active high per bit
//   LCD_rw      out  tied to 0 (write only)
//   LCD_di      out  0 = command, 1 = display data
//   LCD_en      out  LCD strobe, the LCD latches on its falling edge
//   LCD_data    out  LCD data bus
module lcd_ctrl #(
    parameter int         EN_CYCLES  = 8,
    parameter int         RST_CYCLES = 100,
    parameter logic [1:0] CS_SEL     = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic [7:0] data_in,
    output logic       en,
    output logic       frame_done,
    output logic       LCD_rst,
    output logic [1:0] LCD_cs,
    output logic       LCD_rw,
    output logic       LCD_di,
    output logic       LCD_en,
    output logic [7:0] LCD_data
);

    localparam int EW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [EW-1:0] EN_LAST  = EW'(EN_CYCLES - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    localparam logic [7:0] CMD_ON    = 8'h3F;
    localparam logic [7:0] CMD_START = 8'hC0;
    localparam logic [7:0] CMD_YADDR = 8'h40;

    typedef enum logic [1:0] {
        B_IDLE,
        B_SETUP,
        B_HIGH,
        B_HOLD
    } bus_state_t;

    typedef enum logic [3:0] {
        S_RST_WAIT,
        S_ON,
        S_START,
        S_CLR_PAGE,
        S_CLR_YADDR,
        S_CLR_DATA,
        S_PAGE,
        S_YADDR,
        S_REQ,
        S_WAIT,
        S_DATA
    } main_state_t;

    // ------------------------------------------------------------------
    // Bus write sub-FSM
    // ------------------------------------------------------------------
    bus_state_t      bus_state_reg, bus_state_next;
    logic [EW-1:0]   bus_cnt_reg,   bus_cnt_next;
    logic [7:0]      bus_data_reg,  bus_data_next;
    logic            bus_di_reg,    bus_di_next;
    logic [1:0]      bus_cs_reg,    bus_cs_next;

    // Request from the main FSM; only honoured while the bus is idle.
    logic            wr_start;
    logic [7:0]      wr_data;
    logic            wr_di;
    logic [1:0]      wr_cs;
    logic            wr_done;

    // Done is decoded straight from registers so the two comb blocks
    // never depend on each other.
    assign wr_done = (bus_state_reg == B_HOLD) && (bus_cnt_reg == EN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state_reg <= B_IDLE;
            bus_cnt_reg   <= '0;
            bus_data_reg  <= 8'h00;
            bus_di_reg    <= 1'b0;
            bus_cs_reg    <= 2'b00;
        end else begin
            bus_state_reg <= bus_state_next;
            bus_cnt_reg   <= bus_cnt_next;
            bus_data_reg  <= bus_data_next;
            bus_di_reg    <= bus_di_next;
            bus_cs_reg    <= bus_cs_next;
        end
    end

    always_comb begin
        bus_state_next = bus_state_reg;
        bus_cnt_next   = bus_cnt_reg;
        bus_data_next  = bus_data_reg;
        bus_di_next    = bus_di_reg;
        bus_cs_next    = bus_cs_reg;
        case (bus_state_reg)
            B_IDLE: begin
                if (wr_start) begin
                    // Capture everything up front so the bus cannot move
                    // while the main FSM advances.
                    bus_state_next = B_SETUP;
                    bus_cnt_next   = '0;
                    bus_data_next  = wr_data;
                    bus_di_next    = wr_di;
                    bus_cs_next    = wr_cs;
                end
            end
            B_SETUP: begin
                if (bus_cnt_reg == EN_LAST) begin
                    bus_state_next = B_HIGH;
                    bus_cnt_next   = '0;
                end else begin
                    bus_cnt_next = bus_cnt_reg + EW'(1);
                end
            end
            B_HIGH: begin
                if (bus_cnt_reg == EN_LAST) begin
                    bus_state_next = B_HOLD;
                    bus_cnt_next   = '0;
                end else begin
                    bus_cnt_next = bus_cnt_reg + EW'(1);
                end
            end
            B_HOLD: begin
                if (bus_cnt_reg == EN_LAST) begin
                    bus_state_next = B_IDLE;
                    bus_cnt_next   = '0;
                end else begin
                    bus_cnt_next = bus_cnt_reg + EW'(1);
                end
            end
            default: begin
                bus_state_next = B_IDLE;
                bus_cnt_next   = '0;
            end
        endcase
    end

    // Chip selects are only driven while a write is on the bus.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cs
            assign LCD_cs[gi] = (bus_state_reg != B_IDLE) && bus_cs_reg[gi];
        end
    endgenerate

    assign LCD_en   = (bus_state_reg == B_HIGH);
    assign LCD_data = bus_data_reg;
    assign LCD_di   = bus_di_reg;
    assign LCD_rw   = 1'b0;

    // ------------------------------------------------------------------
    // Main sequencing FSM
    // ------------------------------------------------------------------
    main_state_t     state_reg,   state_next;
    logic [2:0]      page_reg,    page_next;
    logic [5:0]      col_reg,     col_next;
    logic [RW-1:0]   rst_cnt_reg, rst_cnt_next;
    logic            lcd_rst_reg, lcd_rst_next;
    logic [7:0]      byte_reg,    byte_next;
    logic            fd_reg,      fd_next;
    logic            wr_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_RST_WAIT;
            page_reg    <= 3'd0;
            col_reg     <= 6'd0;
            rst_cnt_reg <= '0;
            lcd_rst_reg <= 1'b0;
            byte_reg    <= 8'h00;
            fd_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            page_reg    <= page_next;
            col_reg     <= col_next;
            rst_cnt_reg <= rst_cnt_next;
            lcd_rst_reg <= lcd_rst_next;
            byte_reg    <= byte_next;
            fd_reg      <= fd_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        page_next    = page_reg;
        col_next     = col_reg;
        rst_cnt_next = rst_cnt_reg;
        lcd_rst_next = lcd_rst_reg;
        byte_next    = byte_reg;
        fd_next      = 1'b0;
        wr_req       = 1'b0;
        wr_data      = 8'h00;
        wr_di        = 1'b0;
        wr_cs        = 2'b00;
        case (state_reg)
            S_RST_WAIT: begin
                if (rst_cnt_reg == RST_LAST) begin
                    lcd_rst_next = 1'b1;
                    state_next   = S_ON;
                end else begin
                    rst_cnt_next = rst_cnt_reg + RW'(1);
                end
            end
            S_ON: begin
                wr_req  = 1'b1;
                wr_data = CMD_ON;
                wr_cs   = 2'b11;
                if (wr_done) state_next = S_START;
            end
            S_START: begin
                wr_req  = 1'b1;
                wr_data = CMD_START;
                wr_cs   = 2'b11;
                if (wr_done) begin
`ifdef LCD_CLEAR_ON_INIT_EN
                    state_next = S_CLR_PAGE;
`else
                    state_next = S_PAGE;
`endif
                end
            end
`ifdef LCD_CLEAR_ON_INIT_EN
            S_CLR_PAGE: begin
                wr_req  = 1'b1;
                wr_data = {5'b10111, page_reg};
                wr_cs   = 2'b11;
                if (wr_done) state_next = S_CLR_YADDR;
            end
            S_CLR_YADDR: begin
                wr_req  = 1'b1;
                wr_data = CMD_YADDR;
                wr_cs   = 2'b11;
                if (wr_done) state_next = S_CLR_DATA;
            end
            S_CLR_DATA: begin
                wr_req  = 1'b1;
                wr_data = 8'h00;
                wr_di   = 1'b1;
                wr_cs   = 2'b11;
                if (wr_done) begin
                    col_next = col_reg + 6'd1;
                    if (col_reg == 6'd63) begin
                        // page wraps 7 -> 0, so refresh starts on page 0
                        page_next  = page_reg + 3'd1;
                        state_next = (page_reg == 3'd7) ? S_PAGE : S_CLR_PAGE;
                    end
                end
            end
`endif
            S_PAGE: begin
                wr_req  = 1'b1;
                wr_data = {5'b10111, page_reg};
                wr_cs   = CS_SEL;
                if (wr_done) state_next = S_YADDR;
            end
            S_YADDR: begin
                // Y auto-increments in the LCD, so once per page is enough.
                wr_req  = 1'b1;
                wr_data = CMD_YADDR;
                wr_cs   = CS_SEL;
                if (wr_done) state_next = S_REQ;
            end
            S_REQ: begin
                // en is decoded from this state; leaving it at once keeps
                // the request to one clock and makes a same-cycle
                // data_valid land outside WAIT, where it is ignored.
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (data_valid) begin
                    byte_next  = data_in;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                wr_req  = 1'b1;
                wr_data = byte_reg;
                wr_di   = 1'b1;
                wr_cs   = CS_SEL;
                if (wr_done) begin
                    col_next = col_reg + 6'd1;
                    if (col_reg == 6'd63) begin
                        page_next  = page_reg + 3'd1;
                        state_next = S_PAGE;
                        fd_next    = (page_reg == 3'd7);
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end
            default: begin
                state_next = S_RST_WAIT;
            end
        endcase
    end

    // A write state starts its bus transfer on its first cycle; wr_done
    // moves the FSM on in the same cycle the bus returns to idle, so each
    // write state launches exactly one transfer.
    assign wr_start   = wr_req && (bus_state_reg == B_IDLE);

    assign en         = (state_reg == S_REQ);
    assign frame_done = fd_reg;
    assign LCD_rst    = lcd_rst_reg;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Testbench for lcd_ctrl (EN_CYCLES=2, RST_CYCLES=4, CS_SEL=01).
// A randomized byte source answers en requests with random latency, injects
// stray data_valid pulses, and a bus monitor reconstructs every LCD write and
// compares it against the expected command/data stream derived from the
// frame layout (8 pages x (PAGE cmd, YADDR cmd, 64 data bytes)).
module tb_lcd_ctrl;
    localparam int         EN_CYC   = 2;
    localparam int         RST_CYC  = 4;
    localparam logic [1:0] CSS      = 2'b01;
    localparam int         PAGE_WR  = 66;
    localparam int         FRAME_WR = 8 * PAGE_WR;
`ifdef LCD_CLEAR_ON_INIT_EN
    localparam int         BASE     = 2 + FRAME_WR;
`else
    localparam int         BASE     = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       en;
    logic       frame_done;
    logic       LCD_rst;
    logic [1:0] LCD_cs;
    logic       LCD_rw;
    logic       LCD_di;
    logic       LCD_en;
    logic [7:0] LCD_data;

    lcd_ctrl #(
        .EN_CYCLES (EN_CYC),
        .RST_CYCLES(RST_CYC),
        .CS_SEL    (CSS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_valid(data_valid),
        .data_in   (data_in),
        .en        (en),
        .frame_done(frame_done),
        .LCD_rst   (LCD_rst),
        .LCD_cs    (LCD_cs),
        .LCD_rw    (LCD_rw),
        .LCD_di    (LCD_di),
        .LCD_en    (LCD_en),
        .LCD_data  (LCD_data)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  bytes_q[$];     // bytes handed to the DUT, in order
    int          wr_idx      = 0;
    bit          outstanding = 1'b0;
    int          dv_delay    = 0;
    bit          en_allowed  = 1'b0;
    bit          mon_active  = 1'b0;
    int          mon_len     = 0;
    int          mon_en      = 0;
    logic [10:0] mon_snap    = '0;
    int          data_writes = 0;
    int          frames      = 0;
    int          lat_min     = 1;
    int          lat_max     = 3;

    // Called on the first sample after a write leaves the bus.
    task automatic finish_write();
        logic [10:0] exp_bus;
        logic        exp_fd;
        logic [7:0]  b;
        int          k;
        int          p;
        int          r;
        exp_fd  = 1'b0;
        exp_bus = '0;
        check("wr_len", mon_len, 3 * EN_CYC);
        check("wr_en_high", mon_en, EN_CYC);
        check("wr_rw", LCD_rw, 1'b0);
        if (wr_idx == 0) begin
            exp_bus = {2'b11, 1'b0, 8'h3F};
        end else if (wr_idx == 1) begin
            exp_bus = {2'b11, 1'b0, 8'hC0};
        end else if (wr_idx < BASE) begin
            k = wr_idx - 2;
            p = k / PAGE_WR;
            r = k % PAGE_WR;
            if (r == 0)      exp_bus = {2'b11, 1'b0, 8'(184 + p)};
            else if (r == 1) exp_bus = {2'b11, 1'b0, 8'h40};
            else             exp_bus = {2'b11, 1'b1, 8'h00};
        end else begin
            k = (wr_idx - BASE) % FRAME_WR;
            p = k / PAGE_WR;
            r = k % PAGE_WR;
            if (r == 0) begin
                exp_bus = {CSS, 1'b0, 8'(184 + p)};
            end else if (r == 1) begin
                exp_bus = {CSS, 1'b0, 8'h40};
            end else begin
                check("byte_avail", bytes_q.size() > 0, 1'b1);
                b = (bytes_q.size() > 0) ? bytes_q.pop_front() : 8'h00;
                exp_bus = {CSS, 1'b1, b};
                data_writes++;
            end
            en_allowed = (r >= 1) && (r <= 64);
            exp_fd     = (p == 7) && (r == 65);
            if (exp_fd) frames++;
        end
        check("wr_bus", mon_snap, exp_bus);
        check("frame_done", frame_done, exp_fd);
        $display("write %0d: cs=%b di=%b data=%02h fd=%b", wr_idx, mon_snap[10:9],
                 mon_snap[8], mon_snap[7:0], frame_done);
        wr_idx++;
    endtask

    // Bus monitor and byte source, sampled on the falling edge.
    initial begin
        logic [7:0] b;
        bit         ended;
        forever begin
            @(negedge clk);
            data_valid = 1'b0;
            if (rst) begin
                wr_idx      = 0;
                bytes_q.delete();
                outstanding = 1'b0;
                en_allowed  = 1'b0;
                mon_active  = 1'b0;
            end else begin
                ended = 1'b0;
                if (LCD_cs != 2'b00) begin
                    if (!mon_active) begin
                        mon_active = 1'b1;
                        mon_len    = 0;
                        mon_en     = 0;
                        mon_snap   = {LCD_cs, LCD_di, LCD_data};
                        check("en_missing", en_allowed, 1'b0);
                    end else begin
                        check("bus_stable", {LCD_cs, LCD_di, LCD_data}, mon_snap);
                    end
                    mon_len++;
                    if (LCD_en) mon_en++;
                end else begin
                    if (LCD_en) check("en_without_cs", LCD_en, 1'b0);
                    if (mon_active) begin
                        mon_active = 1'b0;
                        ended      = 1'b1;
                        finish_write();
                    end
                end
                if (!ended && frame_done) check("fd_stray", frame_done, 1'b0);

                if (en) begin
                    check("en_unexp", en_allowed, 1'b1);
                    check("en_dup", outstanding, 1'b0);
                    en_allowed  = 1'b0;
                    outstanding = 1'b1;
                    dv_delay    = int'($urandom_range(lat_max, lat_min));
                    // Zero-latency answer: must be ignored by the DUT.
                    if ($urandom_range(3, 0) == 0) begin
                        data_valid = 1'b1;
                        data_in    = 8'($urandom);
                    end
                end else if (outstanding) begin
                    check("wait_bus_idle", {LCD_cs, LCD_en}, 3'b000);
                    dv_delay--;
                    if (dv_delay <= 0) begin
                        b           = 8'($urandom);
                        data_valid  = 1'b1;
                        data_in     = b;
                        bytes_q.push_back(b);
                        outstanding = 1'b0;
                    end
                end else if ($urandom_range(7, 0) == 0) begin
                    // Stray pulse with no request outstanding: must be dropped.
                    data_valid = 1'b1;
                    data_in    = 8'($urandom);
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_en"}, en, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_LCD_rst"}, LCD_rst, 1'b0);
        check({tag, "_LCD_cs"}, LCD_cs, 2'b00);
        check({tag, "_LCD_rw"}, LCD_rw, 1'b0);
        check({tag, "_LCD_di"}, LCD_di, 1'b0);
        check({tag, "_LCD_en"}, LCD_en, 1'b0);
        check({tag, "_LCD_data"}, LCD_data, 8'h00);
    endtask

    // Called just after a rising edge; counts clocks until LCD_rst rises.
    task automatic release_and_count();
        int n;
        n   = 0;
        rst = 1'b0;
        while (!LCD_rst && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_wait_len", n, RST_CYC);
    endtask

    initial begin
        int c;
        int snap;

        // Power-up reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        release_and_count();

        // Two full frames with short random latency
        c = 0;
        while (frames < 2 && c < 30000) begin
            @(posedge clk);
            c++;
        end
        check("two_frames", frames >= 2, 1'b1);

        // Slow source: 20-clock latency
        lat_min = 20;
        lat_max = 20;
        snap = data_writes;
        c = 0;
        while (data_writes < snap + 5 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        check("slow_progress", data_writes >= snap + 5, 1'b1);
        lat_min = 1;
        lat_max = 3;

        // Reset in the middle of the HIGH phase of a data write
        c = 0;
        @(posedge clk);
        #1;
        while (!(LCD_en && LCD_di) && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("found_data_high", LCD_en && LCD_di, 1'b1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("mid_write");
        @(posedge clk);
        #1;
        release_and_count();

        // Sequence restarts from the beginning
        snap = data_writes;
        c = 0;
        while (data_writes < snap + 70 && c < 20000) begin
            @(posedge clk);
            c++;
        end
        check("restart_progress", data_writes >= snap + 70, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
